// File: rtl/bm2fxp_denorm.sv
// bm2fxp_denorm: block-minifloat to fixed-point expander.
//
// Takes beats of num_output packed minifloat elements {sign, exp, man} plus a
// signed shared exponent per block. Each element is rebuilt as a two's
// complement fixed-point value of data_width bits. Two register stages sit
// behind a single valid/ready handshake.
//
// Optional build macro: BM2FXP_SAT_EN
//   defined   -> overflowing magnitudes clamp to 2^(data_width-1)-1 and
//                dn_sat flags any beat that holds a clamped element
//   undefined -> overflowing magnitudes wrap to their low data_width-1 bits
//                and dn_sat is held at 0
module bm2fxp_denorm #(
    parameter int EBIT       = 2,
    parameter int MBIT       = 1,
    parameter int bm_width   = 4,
    parameter int data_width = 16,
    parameter int num_output = 8,
    parameter int BIAS       = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             up_vld,
    output logic                             up_rdy,
    input  logic [num_output*bm_width-1:0]   up_dat,
    input  logic [7:0]                       up_ps,
    input  logic [15:0]                      length,
    output logic                             dn_vld,
    input  logic                             dn_rdy,
    output logic [num_output*data_width-1:0] dn_dat,
    output logic                             dn_last,
    output logic                             dn_sat
);

    // Beats per block are derived by shifting the element count, so the
    // lane count has to be a power of two.
    localparam int LOG2N = $clog2(num_output);
    localparam int SIGW  = MBIT + 1;
    localparam int WIDEW = data_width + MBIT + 1;

    // Exponent arithmetic runs in 10-bit signed precision.
    localparam logic signed [9:0] BIAS10 = 10'(BIAS);
    localparam logic signed [9:0] MBIT10 = 10'(MBIT);
    localparam logic signed [9:0] DW10   = 10'(data_width);

    // Largest magnitude that still fits below the sign bit.
    localparam logic [data_width-2:0] MAGMAX = '1;

`ifdef BM2FXP_SAT_EN
    localparam logic SatEnabled = 1'b1;
`else
    localparam logic SatEnabled = 1'b0;
`endif

    // Handshake and framing
    logic        w_en;
    logic        w_accept;
    logic        w_blockStart;
    logic        w_lastIn;
    logic [15:0] w_bpbIn;
    logic [15:0] w_bpbNow;
    logic [7:0]  w_psNow;
    logic signed [9:0] w_psExt;

    logic [15:0] r_beatCnt;
    logic [15:0] r_bpbHold;
    logic [7:0]  r_psHold;

    // Stage 1 decode (combinational) and registers
    logic [EBIT-1:0]   w_exp     [num_output];
    logic [MBIT-1:0]   w_man     [num_output];
    logic              w_s1Sign  [num_output];
    logic [SIGW-1:0]   w_s1Sig   [num_output];
    logic signed [9:0] w_s1Shift [num_output];

    logic              r_s1Vld;
    logic              r_s1Last;
    logic              r_s1Sign  [num_output];
    logic [SIGW-1:0]   r_s1Sig   [num_output];
    logic signed [9:0] r_s1Shift [num_output];

    // Stage 2 shift/sign (combinational) and output registers
    logic [WIDEW-1:0]      w_wide   [num_output];
    logic [9:0]            w_negAmt [num_output];
    logic                  w_ovf    [num_output];
    logic [data_width-2:0] w_mag    [num_output];
    logic [num_output*data_width-1:0] w_dnDatNext;
    logic                  w_satAny;

    logic                             r_dnVld;
    logic [num_output*data_width-1:0] r_dnDat;
    logic                             r_dnLast;
    logic                             r_dnSat;

    // The whole pipe moves only when the output register is free or being
    // drained; a stalled output therefore also blocks the input side.
    assign w_en     = !r_dnVld || dn_rdy;
    assign up_rdy   = w_en;
    assign w_accept = up_vld && w_en;

    // A block shorter than one beat still occupies one beat.
    assign w_bpbIn = ((length >> LOG2N) == 16'd0) ? 16'd1 : (length >> LOG2N);

    // The first beat of a block uses the live exponent/length; later beats
    // use the copies captured on that first beat.
    assign w_blockStart = (r_beatCnt == 16'd0);
    assign w_bpbNow     = w_blockStart ? w_bpbIn : r_bpbHold;
    assign w_psNow      = w_blockStart ? up_ps : r_psHold;
    assign w_lastIn     = (r_beatCnt == (w_bpbNow - 16'd1));
    assign w_psExt      = {{2{w_psNow[7]}}, w_psNow};

    // Split every lane into sign, significand and a signed shift distance.
    always_comb begin
        for (int j = 0; j < num_output; j++) begin
            w_exp[j]    = up_dat[j*bm_width + MBIT +: EBIT];
            w_man[j]    = up_dat[j*bm_width +: MBIT];
            w_s1Sign[j] = up_dat[j*bm_width + bm_width - 1];
            if (w_exp[j] != '0) begin
                w_s1Sig[j]   = {1'b1, w_man[j]};
                w_s1Shift[j] = $signed(10'(w_exp[j])) - BIAS10 + w_psExt - MBIT10;
            end else begin
                w_s1Sig[j]   = {1'b0, w_man[j]};
                w_s1Shift[j] = w_psExt - BIAS10 - MBIT10 + 10'sd1;
            end
        end
    end

    // Beat counter plus the per-block exponent/length captured on block start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beatCnt <= 16'd0;
            r_bpbHold <= 16'd0;
            r_psHold  <= 8'd0;
        end else if (w_accept) begin
            if (w_blockStart) begin
                r_bpbHold <= w_bpbIn;
                r_psHold  <= up_ps;
            end
            r_beatCnt <= w_lastIn ? 16'd0 : (r_beatCnt + 16'd1);
        end
    end

    // Stage 1 register: decoded lanes and the end-of-block tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Vld  <= 1'b0;
            r_s1Last <= 1'b0;
            for (int j = 0; j < num_output; j++) begin
                r_s1Sign[j]  <= 1'b0;
                r_s1Sig[j]   <= '0;
                r_s1Shift[j] <= '0;
            end
        end else if (w_en) begin
            r_s1Vld  <= up_vld;
            r_s1Last <= up_vld && w_lastIn;
            for (int j = 0; j < num_output; j++) begin
                r_s1Sign[j]  <= w_s1Sign[j];
                r_s1Sig[j]   <= w_s1Sig[j];
                r_s1Shift[j] <= w_s1Shift[j];
            end
        end
    end

    // Shift each significand into place, detect overflow, then apply the sign.
    // Left shifts of data_width or more are handled as a pure overflow case
    // because every surviving low bit would be zero anyway.
    always_comb begin
        w_dnDatNext = '0;
        w_satAny    = 1'b0;
        for (int j = 0; j < num_output; j++) begin
            w_negAmt[j] = 10'(-r_s1Shift[j]);
            if (r_s1Shift[j] < 10'sd0) begin
                w_wide[j] = WIDEW'(r_s1Sig[j]) >> w_negAmt[j];
            end else if (r_s1Shift[j] >= DW10) begin
                w_wide[j] = '0;
            end else begin
                w_wide[j] = WIDEW'(r_s1Sig[j]) << unsigned'(r_s1Shift[j]);
            end
            w_ovf[j] = ((r_s1Shift[j] >= DW10) && (r_s1Sig[j] != '0)) ||
                       (w_wide[j][WIDEW-1:data_width-1] != '0);
            w_mag[j] = (SatEnabled && w_ovf[j]) ? MAGMAX : w_wide[j][data_width-2:0];
            w_dnDatNext[j*data_width +: data_width] =
                r_s1Sign[j] ? -{1'b0, w_mag[j]} : {1'b0, w_mag[j]};
            w_satAny = w_satAny | (SatEnabled & w_ovf[j]);
        end
    end

    // Stage 2 register: output beat, held steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dnVld  <= 1'b0;
            r_dnDat  <= '0;
            r_dnLast <= 1'b0;
            r_dnSat  <= 1'b0;
        end else if (w_en) begin
            r_dnVld  <= r_s1Vld;
            r_dnDat  <= w_dnDatNext;
            r_dnLast <= r_s1Last;
            r_dnSat  <= r_s1Vld && w_satAny;
        end
    end

    assign dn_vld  = r_dnVld;
    assign dn_dat  = r_dnDat;
    assign dn_last = r_dnLast;
    assign dn_sat  = r_dnSat;

endmodule

// File: tb/tb_bm2fxp_denorm.sv
// tb_bm2fxp_denorm: directed bench for bm2fxp_denorm with an arithmetic
// reference model, a per-cycle compare process and literal spot values.
module tb_bm2fxp_denorm;

    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int BW   = 4;
    localparam int BIAS = 1;
    localparam int MBIT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            up_vld;
    logic            up_rdy;
    logic [N*BW-1:0] up_dat;
    logic [7:0]      up_ps;
    logic [15:0]     length;
    logic            dn_vld;
    logic            dn_rdy;
    logic [N*DW-1:0] dn_dat;
    logic            dn_last;
    logic            dn_sat;

    bm2fxp_denorm #(
        .EBIT(2), .MBIT(MBIT), .bm_width(BW), .data_width(DW),
        .num_output(N), .BIAS(BIAS)
    ) dut (
        .clk(clk), .rst(rst),
        .up_vld(up_vld), .up_rdy(up_rdy), .up_dat(up_dat),
        .up_ps(up_ps), .length(length),
        .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_dat(dn_dat),
        .dn_last(dn_last), .dn_sat(dn_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] dat;
        bit              last;
        bit              sat;
        int              acceptCycle;
        int              stallsAtAccept;
    } beat_t;

    beat_t           expQ[$];
    logic [N*DW-1:0] obsDat[$];
    bit              obsLast[$];
    bit              obsSat[$];

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;
    int stalls      = 0;
    int mCnt        = 0;
    int mBpb        = 1;
    logic [7:0] mPs = 8'd0;
    bit prevStall   = 0;
    bit expectIdle  = 0;
    logic [N*DW-1:0] prevDat;
    bit prevLast;
    bit prevSat;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value of one element straight from the number format: significand
    // scaled by a power of two, truncated, then overflow handling and sign.
    function automatic logic [15:0] modelElem(input logic [3:0] el, input int ps, output bit ovf);
        int e, m, sig, shift;
        longint mag;
        e   = int'(el[2:1]);
        m   = int'(el[0]);
        ovf = 0;
        if (e != 0) begin
            sig   = 2 + m;
            shift = e - BIAS + ps - MBIT;
        end else begin
            sig   = m;
            shift = ps - BIAS - MBIT + 1;
        end
        if (sig == 0) mag = 0;
        else if (shift >= 40) begin ovf = 1; mag = 0; end
        else if (shift >= 0) mag = longint'(sig) << shift;
        else if (shift <= -31) mag = 0;
        else mag = longint'(sig >> (-shift));
        if (mag >= 32768) ovf = 1;
`ifdef BM2FXP_SAT_EN
        if (ovf) mag = 32767;
`else
        mag = mag % 32768;
`endif
        return el[3] ? 16'(-mag) : 16'(mag);
    endfunction

    // Record what an accepted beat must turn into.
    task automatic modelAccept();
        beat_t b;
        bit ovf;
        bit anyOvf;
        anyOvf = 0;
        b.dat  = '0;
        if (mCnt == 0) begin
            mBpb = int'(length) / N;
            if (mBpb == 0) mBpb = 1;
            mPs = up_ps;
        end
        b.last = (mCnt == mBpb - 1);
        mCnt   = b.last ? 0 : mCnt + 1;
        for (int j = 0; j < N; j++) begin
            b.dat[j*DW +: DW] = modelElem(up_dat[j*BW +: BW], int'($signed(mPs)), ovf);
            anyOvf = anyOvf | ovf;
        end
`ifdef BM2FXP_SAT_EN
        b.sat = anyOvf;
`else
        b.sat = 0;
`endif
        b.acceptCycle    = cyc;
        b.stallsAtAccept = stalls;
        expQ.push_back(b);
    endtask

    // Mid-cycle compare process: inputs and outputs are both settled here.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expQ.delete();
            mCnt       = 0;
            mBpb       = 1;
            mPs        = 8'd0;
            prevStall  = 0;
            expectIdle = 1;
        end else begin
            if (expectIdle) begin
                checkOutput("reset_dn_vld", dn_vld, 1'b0);
                checkOutput("reset_dn_dat", dn_dat, '0);
                checkOutput("reset_dn_last", dn_last, 1'b0);
                checkOutput("reset_dn_sat", dn_sat, 1'b0);
                checkOutput("reset_up_rdy", up_rdy, 1'b1);
                expectIdle = 0;
            end
            checkOutput("up_rdy", up_rdy, !(dn_vld && !dn_rdy));
            if (prevStall) begin
                checkOutput("hold_vld", dn_vld, 1'b1);
                checkOutput("hold_dat", dn_dat, prevDat);
                checkOutput("hold_last", dn_last, prevLast);
                checkOutput("hold_sat", dn_sat, prevSat);
            end
            if (dn_vld && dn_rdy) begin
                if (expQ.size() == 0) begin
                    totalChecks++;
                    badChecks++;
                    $display("[TB] FAIL extra_beat: got dat %0h with nothing outstanding", dn_dat);
                end else begin
                    beat_t b;
                    b = expQ.pop_front();
                    checkOutput("dn_dat", dn_dat, b.dat);
                    checkOutput("dn_last", dn_last, b.last);
                    checkOutput("dn_sat", dn_sat, b.sat);
                    checkOutput("latency", cyc, b.acceptCycle + 2 + (stalls - b.stallsAtAccept));
                end
                obsDat.push_back(dn_dat);
                obsLast.push_back(dn_last);
                obsSat.push_back(dn_sat);
            end
            if (dn_vld && !dn_rdy) stalls++;
            prevStall = dn_vld && !dn_rdy;
            prevDat   = dn_dat;
            prevLast  = dn_last;
            prevSat   = dn_sat;
            if (up_vld && up_rdy) modelAccept();
        end
    end

    function automatic logic [15:0] obsLane(input int k, input int j);
        if (k >= obsDat.size()) return 16'hDEAD;
        return obsDat[k][j*DW +: DW];
    endfunction

    function automatic logic [1:0] obsLastAt(input int k);
        if (k >= obsLast.size()) return 2'b10;
        return {1'b0, obsLast[k]};
    endfunction

    function automatic logic [1:0] obsSatAt(input int k);
        if (k >= obsSat.size()) return 2'b10;
        return {1'b0, obsSat[k]};
    endfunction

    task automatic clearObs();
        obsDat.delete();
        obsLast.delete();
        obsSat.delete();
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic applyStimulus(input logic [31:0] dat, input logic [7:0] ps, input logic [15:0] len);
        bit done;
        done   = 0;
        up_dat = dat;
        up_ps  = ps;
        length = len;
        up_vld = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = up_rdy;
            @(posedge clk);
            #3;
        end
        up_vld = 1'b0;
        if (!done) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL accept_timeout: up_rdy stayed 0, required 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput("drain_outstanding", expQ.size(), 0);
        @(posedge clk);
        #3;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        up_vld = 1'b0;
        up_dat = '0;
        up_ps  = 8'd0;
        length = 16'd0;
        dn_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #3;

        $display("[TB] normal decode");
        clearObs();
        applyStimulus(32'h55555555, 8'd4, 16'd8);
        drain();
        checkOutput("t1_count", obsDat.size(), 1);
        checkOutput("t1_lane0", obsLane(0, 0), 16'h0030);
        checkOutput("t1_lane7", obsLane(0, 7), 16'h0030);
        checkOutput("t1_last", obsLastAt(0), 2'b01);

        $display("[TB] subnormal, negative, zero");
        clearObs();
        applyStimulus(32'h28D128D1, 8'd4, 16'd8);
        drain();
        checkOutput("t2_sub", obsLane(0, 0), 16'h0008);
        checkOutput("t2_neg", obsLane(0, 1), 16'hFFD0);
        checkOutput("t2_zero", obsLane(0, 2), 16'h0000);
        checkOutput("t2_e1", obsLane(0, 3), 16'h0010);
        checkOutput("t2_rep", obsLane(0, 5), 16'hFFD0);

        $display("[TB] negative shared exponent");
        clearObs();
        applyStimulus(32'h000015F7, 8'hFF, 16'd8);
        drain();
        checkOutput("t2b_pos", obsLane(0, 0), 16'h0003);
        checkOutput("t2b_neg", obsLane(0, 1), 16'hFFFD);
        checkOutput("t2b_trunc", obsLane(0, 2), 16'h0001);
        checkOutput("t2b_sub0", obsLane(0, 3), 16'h0000);

        $display("[TB] framing");
        clearObs();
        applyStimulus(32'h55555555, 8'd4, 16'd32);
        applyStimulus(32'h55555555, 8'd9, 16'd32);
        applyStimulus(32'h55555555, 8'd9, 16'd32);
        applyStimulus(32'h55555555, 8'd9, 16'd32);
        applyStimulus(32'h55555555, 8'd2, 16'd32);
        applyStimulus(32'h55555555, 8'd7, 16'd32);
        applyStimulus(32'h55555555, 8'd7, 16'd32);
        applyStimulus(32'h55555555, 8'd7, 16'd32);
        drain();
        checkOutput("t3_beat2_ps", obsLane(1, 0), 16'h0030);
        checkOutput("t3_beat3_last", obsLastAt(2), 2'b00);
        checkOutput("t3_beat4_last", obsLastAt(3), 2'b01);
        checkOutput("t3_beat5_ps", obsLane(4, 0), 16'h000C);
        checkOutput("t3_beat6_ps", obsLane(5, 3), 16'h000C);
        checkOutput("t3_beat8_last", obsLastAt(7), 2'b01);

        $display("[TB] backpressure");
        clearObs();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    applyStimulus(32'h13579BDF + 32'(i) * 32'h11111111, 8'(i * 3 - 10), 16'd64);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #3;
                dn_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #3;
                dn_rdy = 1'b1;
            end
        join
        drain();
        checkOutput("t4_count", obsDat.size(), 16);
        checkOutput("t4_first_last", obsLastAt(0), 2'b00);
        checkOutput("t4_mid_last", obsLastAt(7), 2'b01);
        checkOutput("t4_end_last", obsLastAt(15), 2'b01);

        $display("[TB] overflow");
        clearObs();
        applyStimulus(32'h000000F7, 8'd20, 16'd8);
        applyStimulus(32'h00000132, 8'd15, 16'd8);
        drain();
`ifdef BM2FXP_SAT_EN
        checkOutput("t5_pos", obsLane(0, 0), 16'h7FFF);
        checkOutput("t5_neg", obsLane(0, 1), 16'h8001);
        checkOutput("t5_sat", obsSatAt(0), 2'b01);
        checkOutput("t5_edge", obsLane(1, 0), 16'h7FFF);
        checkOutput("t5_above", obsLane(1, 1), 16'h7FFF);
        checkOutput("t5_sat2", obsSatAt(1), 2'b01);
`else
        checkOutput("t5_pos", obsLane(0, 0), 16'h0000);
        checkOutput("t5_neg", obsLane(0, 1), 16'h0000);
        checkOutput("t5_sat", obsSatAt(0), 2'b00);
        checkOutput("t5_edge", obsLane(1, 0), 16'h0000);
        checkOutput("t5_above", obsLane(1, 1), 16'h4000);
        checkOutput("t5_sat2", obsSatAt(1), 2'b00);
`endif
        checkOutput("t5_fits", obsLane(1, 2), 16'h4000);

        $display("[TB] reset mid-block");
        applyStimulus(32'h55555555, 8'd4, 16'd32);
        applyStimulus(32'h55555555, 8'd4, 16'd32);
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #3;
        clearObs();
        applyStimulus(32'h55555555, 8'd6, 16'd32);
        applyStimulus(32'h55555555, 8'd1, 16'd32);
        applyStimulus(32'h55555555, 8'd1, 16'd32);
        applyStimulus(32'h55555555, 8'd1, 16'd32);
        drain();
        checkOutput("t6_count", obsDat.size(), 4);
        checkOutput("t6_fresh_ps", obsLane(0, 0), 16'h00C0);
        checkOutput("t6_first_last", obsLastAt(0), 2'b00);
        checkOutput("t6_held_ps", obsLane(3, 0), 16'h00C0);
        checkOutput("t6_end_last", obsLastAt(3), 2'b01);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
